// File: rtl/bitstream_gen_double.sv
// Double-buffered unary bitstream generator: a value waits in a shadow register while the
// active value streams, and each period emits `active` ones in bit-reversed counter order.
module bitstream_gen_double #(
  parameter int BWID = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iValid,
  input  logic [BWID-1:0] iData,
  output logic            oReady,
  input  logic            iHold,
  output logic            oBit,
  output logic            oValid,
  output logic            oLast
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [BWID-1:0] ZERO_C = {BWID{1'b0}};
  localparam logic [BWID-1:0] ONE_C  = {{(BWID-1){1'b0}}, 1'b1};
  localparam logic [BWID-1:0] MAX_C  = {BWID{1'b1}};

  // Reverse the bit order of the period counter.
  function automatic logic [BWID-1:0] bitrev(input logic [BWID-1:0] v);
    logic [BWID-1:0] r;
    for (int i = 0; i < BWID; i++) begin
      r[i] = v[BWID-1-i];
    end
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [BWID-1:0] cnt_r, cnt_s;
  logic [BWID-1:0] active_r, active_s;
  logic [BWID-1:0] shadow_r, shadow_s;
  logic            svalid_r, svalid_s;
  logic            load_s;

  // Stream handshake and output bit, all decoded from current state.
  always_comb begin
    oReady = ~svalid_r;
    load_s = iValid & ~svalid_r;
    oValid = (state_r == RUN) & ~iHold;
    oLast  = oValid & (cnt_r == MAX_C);
    oBit   = oValid & (active_r > bitrev(cnt_r));
  end

  // Next-state logic: swap the shadow into active when idle or at the end of a period.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    active_s = active_r;
    shadow_s = shadow_r;
    svalid_s = svalid_r;
    case (state_r)
      IDLE: begin
        if (svalid_r) begin
          active_s = shadow_r;
          svalid_s = 1'b0;
          cnt_s    = ZERO_C;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (oValid) begin
          cnt_s = cnt_r + ONE_C;
          if (oLast) begin
            if (svalid_r) begin
              active_s = shadow_r;
              svalid_s = 1'b0;
              state_s  = RUN;
            end else begin
              state_s  = IDLE;
            end
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A load only happens while the shadow is empty, so it never collides with a swap.
    if (load_s) begin
      shadow_s = iData;
      svalid_s = 1'b1;
    end else begin
      shadow_s = shadow_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= ZERO_C;
      active_r <= ZERO_C;
      shadow_r <= ZERO_C;
      svalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      active_r <= active_s;
      shadow_r <= shadow_s;
      svalid_r <= svalid_s;
    end
  end

endmodule

// File: tb/tb_bitstream_gen_double.sv
// Scoreboard bench for bitstream_gen_double (BWID=4): expected stream bits come from
// hand-computed per-value masks and are checked by an independent monitor.
module tb_bitstream_gen_double;

  logic       clk;
  logic       rst;
  logic       iValid;
  logic [3:0] iData;
  logic       oReady;
  logic       iHold;
  logic       oBit;
  logic       oValid;
  logic       oLast;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   ones_q[$];
  int   ones_acc;
  int   n_checks;
  int   n_errors;

  bitstream_gen_double #(.BWID(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .iValid (iValid),
    .iData  (iData),
    .oReady (oReady),
    .iHold  (iHold),
    .oBit   (oBit),
    .oValid (oValid),
    .oLast  (oLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which counter positions carry a one for a given value (bit i = cnt i).
  function automatic logic [15:0] mask_of(input logic [3:0] v);
    case (v)
      4'd0:    return 16'h0000;
      4'd3:    return 16'h0111;
      4'd5:    return 16'h1115;
      4'd9:    return 16'h5557;
      4'd15:   return 16'h7FFF;
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    iValid = 1'b0;
    iHold  = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    ones_q.delete();
    ones_acc = 0;
  endtask

  task automatic load(input logic [3:0] v);
    logic [15:0] m;
    int guard;
    guard = 0;
    while (!oReady && guard < 100) begin
      tick();
      guard++;
    end
    if (!oReady) check("load_wait_timeout", 32'd0, 32'd1);
    m = mask_of(v);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{b: m[i], last: (i == 15)});
    end
    ones_q.push_back(int'(v));
    iValid = 1'b1;
    iData  = v;
    tick();
    iValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || oValid) && guard < 300) begin
      tick();
      guard++;
    end
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_idle_ready"}, {oValid, oReady}, 32'b01);
  endtask

  // Monitor: every valid stream bit is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && oValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_bit", oBit, e.b);
          check("stream_last", oLast, e.last);
          if (oBit) ones_acc++;
          if (oLast) begin
            if (ones_q.size() != 0) check("period_ones", ones_acc, ones_q.pop_front());
            else check("period_ones_unexpected", 32'd1, 32'd0);
            ones_acc = 0;
          end
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    ones_acc = 0;
    rst      = 1'b1;
    iValid   = 1'b0;
    iData    = 4'd0;
    iHold    = 1'b0;
    tick();
    do_reset();
    check("reset_outputs", {oValid, oBit, oLast, oReady}, 32'b0001);

    // Single period of 5, with the two-cycle load latency.
    load(4'd5);
    check("latency_t1", oValid, 1'b0);
    tick();
    check("latency_t2", oValid, 1'b1);
    drain("single5");

    // Ping-pong: 9 loaded into the shadow while 5 streams.
    load(4'd5);
    load(4'd9);
    check("shadow_full", oReady, 1'b0);
    begin
      int guard;
      guard = 0;
      while (!oLast && guard < 40) begin
        tick();
        guard++;
      end
      check("first_last_seen", oLast, 1'b1);
    end
    tick();
    check("no_gap_valid", oValid, 1'b1);
    check("ready_after_swap", oReady, 1'b1);
    drain("pingpong");

    // Hold for three cycles on a position that would otherwise emit a one.
    load(4'd5);
    tick();
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      iHold = 1'b1;
      #1;
      check("hold_quiet", {oValid, oBit, oLast}, 32'b000);
      tick();
    end
    iHold = 1'b0;
    drain("hold");

    // Extremes, the second loaded while iHold is high in IDLE.
    load(4'd0);
    drain("zero");
    iHold = 1'b1;
    load(4'd15);
    check("load_under_hold", oReady, 1'b0);
    iHold = 1'b0;
    drain("full");

    // Reset mid-period with the shadow full, then a fresh load.
    load(4'd5);
    load(4'd9);
    repeat (6) tick();
    check("pre_reset_shadow_full", oReady, 1'b0);
    do_reset();
    check("mid_reset_outputs", {oValid, oBit, oLast, oReady}, 32'b0001);
    tick();
    check("post_reset_idle", {oValid, oReady}, 32'b01);
    load(4'd3);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
